// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB codes, FSM state encodings and lane decode helper for ahb_sram_slave.
// Also provides the `ZeroWord text macro used for idle read data.

`ifndef AHB_SRAM_SLAVE_DEFS
`define AHB_SRAM_SLAVE_DEFS
`define ZeroWord 32'h0000_0000
`endif

package ahb_sram_slave_pkg;

    // HTRANS codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE codes
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // HRESP codes
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Slave FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_ERR1    = 3'd4;
    localparam logic [2:0] ST_ERR2    = 3'd5;

    // Byte-lane mask for a transfer; sizes above word use all four lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << lsb;
            HSIZE_HALF: mask = lsb[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_ram.sv
// Synchronous single-port RAM: 32-bit words, per-byte write enable,
// one-cycle read latency. Read data holds until the next read.

module ahb_sram_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read of the storage array
    // NOTE: the array has no reset on purpose; clearing it would need one write per word, so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave front-end for an on-chip single-port SRAM.
// Zero-wait writes, reads with WAIT_STATES extra wait cycles, two-cycle ERROR
// response for bad transfers when the AHB_SRAM_ERR_EN macro is defined.

module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        S_HSEL,
    input  logic [31:0] S_HADDR,
    input  logic [1:0]  S_HTRANS,
    input  logic [2:0]  S_HSIZE,
    input  logic [2:0]  S_HBURST,
    input  logic        S_HWRITE,
    input  logic [31:0] S_HWDATA,
    input  logic        S_HREADY,
    output logic        S_HREADYOUT,
    output logic [1:0]  S_HRESP,
    output logic [31:0] S_HRDATA
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [3:0]            wait_q, wait_d;
    logic                  rd_issued_q, rd_issued_d;
    logic [31:0]           hold_q, hold_d;

    logic                  ready_out;
    logic                  accept;
    logic                  req_err;
    logic [3:0]            req_be;
    logic                  ram_rd_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    // Burst type is irrelevant (each beat stands alone) and only some address bits are decoded.
    logic unused_inputs;
    assign unused_inputs = ^{S_HBURST, S_HADDR};

    // Slave ready decoded from the registered state only
    always_comb begin
        ready_out = (state_q != ST_RD_WAIT) && (state_q != ST_ERR1);
    end

    assign S_HREADYOUT = ready_out;

`ifdef AHB_SRAM_ERR_EN
    assign S_HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign S_HRESP = HRESP_OKAY;
`endif

    // Right after the RAM read the data sits on the RAM port; later it comes from the holding register.
    assign S_HRDATA = (state_q == ST_RD_DATA) ? (rd_issued_q ? ram_rdata : hold_q) : `ZeroWord;

    // Address-phase decode: accept condition, lane mask and error classification
    always_comb begin
        accept  = S_HSEL && S_HREADY && ready_out &&
                  ((S_HTRANS == HTRANS_NONSEQ) || (S_HTRANS == HTRANS_SEQ));
        req_be  = lane_mask(S_HSIZE, S_HADDR[1:0]);
        req_err = 1'b0;
`ifdef AHB_SRAM_ERR_EN
        if (S_HSIZE > HSIZE_WORD) begin
            req_err = 1'b1;
        end else if ((S_HSIZE == HSIZE_HALF) && S_HADDR[0]) begin
            req_err = 1'b1;
        end else if ((S_HSIZE == HSIZE_WORD) && (S_HADDR[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if ((S_HADDR >> (ADDR_WIDTH + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
`endif
    end

    // FSM next state, RAM port control and holding-register update
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wait_d    = wait_q;
        hold_d    = rd_issued_q ? ram_rdata : hold_q;
        ram_rd_en = 1'b0;
        ram_we    = 4'b0000;

        case (state_q)
            ST_WR_DATA: begin
                ram_we = be_q;
            end
            ST_RD_WAIT: begin
                // The counter only equals its load value in the first wait cycle.
                ram_rd_en = (wait_q == WAIT_INIT);
                if (wait_q == 4'd0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
            end
        endcase

        if (accept) begin
            addr_d = S_HADDR[ADDR_WIDTH+1:2];
            be_d   = req_be;
            if (req_err) begin
                state_d = ST_ERR1;
            end else if (S_HWRITE) begin
                state_d = ST_WR_DATA;
            end else begin
                state_d = ST_RD_WAIT;
                wait_d  = WAIT_INIT;
            end
        end else if (ready_out) begin
            state_d = ST_IDLE;
        end

        if (rst) begin
            ram_rd_en = 1'b0;
            ram_we    = 4'b0000;
        end
        rd_issued_d = ram_rd_en;
    end

    // State and transfer registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wait_q      <= 4'd0;
            rd_issued_q <= 1'b0;
            hold_q      <= `ZeroWord;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wait_q      <= wait_d;
            rd_issued_q <= rd_issued_d;
            hold_q      <= hold_d;
        end
    end

    ahb_sram_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rd_en (ram_rd_en),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (S_HWDATA),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a transaction-level response model
// predicts HREADYOUT/HRESP/HRDATA every cycle; directed cases pin the model
// with literal values. Works with or without AHB_SRAM_ERR_EN.

module tb_ahb_sram_slave;

    localparam int AW    = 6;
    localparam int WS    = 3;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        S_HSEL = 1'b0;
    logic [31:0] S_HADDR = 32'd0;
    logic [1:0]  S_HTRANS = 2'b00;
    logic [2:0]  S_HSIZE = 3'd0;
    logic [2:0]  S_HBURST = 3'd0;
    logic        S_HWRITE = 1'b0;
    logic [31:0] S_HWDATA = 32'd0;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [1:0]  S_HRESP;
    logic [31:0] S_HRDATA;
    logic        ext_stall = 1'b0;

    always #5 clk = ~clk;

    // Single-slave bus: global HREADY follows this slave unless another master-side stall is injected.
    assign S_HREADY = S_HREADYOUT & ~ext_stall;

    ahb_sram_slave #(
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .S_HSEL      (S_HSEL),
        .S_HADDR     (S_HADDR),
        .S_HTRANS    (S_HTRANS),
        .S_HSIZE     (S_HSIZE),
        .S_HBURST    (S_HBURST),
        .S_HWRITE    (S_HWRITE),
        .S_HWDATA    (S_HWDATA),
        .S_HREADY    (S_HREADY),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .S_HRDATA    (S_HRDATA)
    );

    // One expected data-phase cycle.
    typedef struct {
        bit       ready;
        bit [1:0] resp;
        bit       is_wr;
        bit       is_rd;
        int       widx;
        bit [3:0] be;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd = 32'd0;
    int          lo_run = 0, last_lo = 0;
    int          err_run = 0, last_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic exp_t mk(bit rdy, bit [1:0] rsp, bit w, bit r, int idx, bit [3:0] b);
        exp_t t;
        t.ready = rdy; t.resp = rsp; t.is_wr = w; t.is_rd = r; t.widx = idx; t.be = b;
        return t;
    endfunction

    // Lanes touched: a transfer of n bytes sits at the n-aligned offset inside the word.
    function automatic bit [3:0] model_be(input bit [2:0] size, input bit [31:0] a);
        int n, base;
        n    = (size >= 3'd2) ? 4 : (1 << size);
        base = int'(a[1:0]) & ~(n - 1);
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic bit model_err(input bit [2:0] size, input bit [31:0] a);
`ifdef AHB_SRAM_ERR_EN
        if (size > 3'd2) return 1'b1;
        if (a >= 32'(4 * DEPTH)) return 1'b1;
        return (a % (32'd1 << size)) != 32'd0;
`else
        return (size == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Per-cycle compare against the model, then model update for the coming edge.
    always @(negedge clk) begin
        cur = mk(1'b1, 2'b00, 1'b0, 1'b0, 0, 4'b0000);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        exp_data = cur.is_rd ? model_mem[cur.widx] : 32'd0;
        check("hreadyout", 32'(S_HREADYOUT), 32'(cur.ready));
        check("hresp", 32'(S_HRESP), 32'(cur.resp));
        check("hrdata", S_HRDATA, exp_data);
        if (cur.is_rd) last_rd = S_HRDATA;

        if (S_HREADYOUT === 1'b0) lo_run++;
        else begin
            if (lo_run > 0) last_lo = lo_run;
            lo_run = 0;
        end
        if (S_HRESP === 2'b01) err_run++;
        else begin
            if (err_run > 0) last_err = err_run;
            err_run = 0;
        end

        if (cur.is_wr && !rst) begin
            for (int b = 0; b < 4; b++)
                if (cur.be[b]) model_mem[cur.widx][8*b +: 8] = S_HWDATA[8*b +: 8];
        end

        if (rst) begin
            exp_q.delete();
        end else if (S_HSEL && S_HREADY && S_HTRANS[1] && cur.ready) begin
            int idx;
            idx = int'((S_HADDR >> 2) % DEPTH);
            if (model_err(S_HSIZE, S_HADDR)) begin
                exp_q.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 0, 4'b0000));
                exp_q.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 0, 4'b0000));
            end else if (S_HWRITE) begin
                exp_q.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, idx, model_be(S_HSIZE, S_HADDR)));
            end else begin
                for (int k = 0; k <= WS; k++)
                    exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 0, 4'b0000));
                exp_q.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, idx, 4'b0000));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        S_HSEL   = 1'b0;
        S_HTRANS = 2'b00;
    endtask

    // Present one address phase and hold it until accepted; drive write data for the data phase.
    task automatic issue(input bit wr, input bit [31:0] addr, input bit [2:0] size, input bit [31:0] wdata);
        bit ok;
        int n;
        S_HSEL   = 1'b1;
        S_HTRANS = 2'b10;
        S_HADDR  = addr;
        S_HWRITE = wr;
        S_HSIZE  = size;
        S_HBURST = 3'(($urandom_range(0, 7)));
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = S_HREADY;
            step();
            n++;
        end
        if (!ok) timeout("accept");
        S_HWDATA = wr ? wdata : $urandom();
        bus_idle();
    endtask

    // Let outstanding data phases finish plus two quiet cycles.
    task automatic drain();
        int n;
        bus_idle();
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) timeout("drain");
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        check("reset_hreadyout", 32'(S_HREADYOUT), 32'd1);
        check("reset_hresp", 32'(S_HRESP), 32'd0);
        check("reset_hrdata", S_HRDATA, 32'd0);

        // Fill every word so reads never return unknown contents.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), 3'd2, 32'hC0DE_0000 | 32'(i));
        drain();

        // Word write then word read.
        issue(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
        issue(1'b0, 32'h10, 3'd2, 32'd0);
        drain();
        check("word_rd", last_rd, 32'hDEAD_BEEF);
        check("rd_wait_cycles", 32'(last_lo), 32'(WS + 1));

        // Byte write into the top lane only.
        issue(1'b1, 32'h10, 3'd2, 32'h1122_3344);
        issue(1'b1, 32'h13, 3'd0, 32'hAA00_0000);
        issue(1'b0, 32'h10, 3'd2, 32'd0);
        drain();
        check("byte_merge", last_rd, 32'hAA22_3344);

        // Halfword write into the upper half.
        issue(1'b1, 32'h16, 3'd1, 32'h5A5A_0000);
        issue(1'b0, 32'h14, 3'd2, 32'd0);
        drain();
        check("half_merge", last_rd, 32'h5A5A_0005);

        // Read straight after write, pipelined.
        issue(1'b1, 32'h20, 3'd2, 32'h5555_AAAA);
        issue(1'b0, 32'h20, 3'd2, 32'd0);
        drain();
        check("raw_b2b", last_rd, 32'h5555_AAAA);

        // Misaligned word accesses.
        issue(1'b1, 32'h00, 3'd2, 32'h0BAD_F00D);
        drain();
        issue(1'b0, 32'h02, 3'd2, 32'd0);
        drain();
`ifdef AHB_SRAM_ERR_EN
        check("err_cycles", 32'(last_err), 32'd2);
        check("err_lo_cycles", 32'(last_lo), 32'd1);
`else
        check("misaligned_rd", last_rd, 32'h0BAD_F00D);
        check("no_err", 32'(last_err), 32'd0);
`endif
        issue(1'b1, 32'h01, 3'd2, 32'hFFFF_FFFF);
        issue(1'b0, 32'h00, 3'd2, 32'd0);
        drain();
`ifdef AHB_SRAM_ERR_EN
        check("err_wr_untouched", last_rd, 32'h0BAD_F00D);
`else
        check("misaligned_wr", last_rd, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a read wait.
        issue(1'b1, 32'h30, 3'd2, 32'h1234_5678);
        issue(1'b0, 32'h30, 3'd2, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_hreadyout", 32'(S_HREADYOUT), 32'd1);
        check("rst_mid_hresp", 32'(S_HRESP), 32'd0);
        check("rst_mid_hrdata", S_HRDATA, 32'd0);
        issue(1'b0, 32'h30, 3'd2, 32'd0);
        drain();
        check("rd_after_rst", last_rd, 32'h1234_5678);
        check("rd_after_rst_wait", 32'(last_lo), 32'(WS + 1));

        // Randomized traffic with idle, BUSY, unselected and stalled cycles mixed in.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bus_idle();
                step();
            end else if (r == 1) begin
                S_HSEL   = $urandom_range(0, 1) == 1;
                S_HTRANS = S_HSEL ? 2'b01 : 2'b10;
                S_HADDR  = $urandom_range(0, 8 * DEPTH - 1);
                S_HWRITE = $urandom_range(0, 1) == 1;
                step();
                bus_idle();
            end else if (r == 2 && exp_q.size() == 0) begin
                ext_stall = 1'b1;
                S_HSEL    = 1'b1;
                S_HTRANS  = 2'b10;
                S_HADDR   = $urandom_range(0, 8 * DEPTH - 1);
                S_HWRITE  = $urandom_range(0, 1) == 1;
                step();
                ext_stall = 1'b0;
                bus_idle();
            end else begin
                issue($urandom_range(0, 1) == 1, $urandom_range(0, 8 * DEPTH - 1),
                      3'($urandom_range(0, 3)), $urandom());
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave endpoint that answers CPU-side AHB masters (instruction fetch and data-memory ports) and backs them with an on-chip single-port SRAM. It accepts single and burst transfers of byte, halfword and word size. It provides zero-wait writes, multi-cycle reads with configurable wait states, and optional ERROR responses. It sits on the slave side of the AHB interconnect, behind the arbiter and decoder.

## Interface
- ADDR_WIDTH, 12, word-address bits; RAM depth is 2^ADDR_WIDTH words.
- WAIT_STATES, 0, extra read wait cycles, 0..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock, reset synchronous and active-high.
- S_HSEL  in  1  slave select from decoder.
- S_HADDR  in  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM.
- S_HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- S_HSIZE  in  3  0=byte, 1=halfword, 2=word.
- S_HBURST  in  3  sampled, ignored; each beat is handled independently.
- S_HWRITE  in  1  1=write.
- S_HWDATA  in  32  write data, valid in the data phase.
- S_HREADY  in  1  bus-wide HREADY; an address phase is accepted only when it is 1.
- S_HREADYOUT  out  1  this slave's ready.
- S_HRESP  out  2  OKAY=00, ERROR=01.
- S_HRDATA  out  32  read data, little-endian natural lanes.

## Operation
- Accept condition at an edge: S_HSEL & S_HREADY & S_HTRANS[1]. On accept, register the word address, byte-enable mask, write flag and error flag.
- Byte enables:
  - HSIZE 0: 1<<addr[1:0].
  - HSIZE 1: addr[1] ? 1100 : 0011.
  - HSIZE 2: 1111.
- IDLE/BUSY transfers and unselected cycles: zero-wait OKAY; no RAM access.
- FSM states: IDLE, WR_DATA, RD_WAIT, RD_DATA, ERR1, ERR2.
  - IDLE: on accepted write -> WR_DATA; on accepted read -> RD_WAIT; on accepted erroneous transfer -> ERR1.
  - WR_DATA: S_HREADYOUT=1. The RAM write uses the registered address/mask and the live S_HWDATA, and commits at the end of the cycle. Next state is decided by the accept condition, as in IDLE.
  - RD_WAIT: S_HREADYOUT=0. The RAM read is issued with the registered address in the first cycle. A wait counter loads WAIT_STATES and stays here until it reaches 0. The RAM data is captured into a holding register.
  - RD_DATA: S_HREADYOUT=1; S_HRDATA = holding register. Next state is decided by the accept condition.
  - ERR1: S_HREADYOUT=0, S_HRESP=ERROR.
  - ERR2: S_HREADYOUT=1, S_HRESP=ERROR. Next state is decided by the accept condition.
- S_HRDATA is 0 in every state except RD_DATA.
- Reads see all prior writes: a write commits in its own data phase, before any later read is issued.
- Reset, including mid-transfer: state=IDLE, S_HREADYOUT=1, S_HRESP=OKAY, S_HRDATA=0, wait counter=0, no RAM write in the reset cycle. RAM contents are not cleared.

## Timing
- Write: address phase at T0; data phase at T1 with S_HREADYOUT=1; RAM updated at the T1 edge. Back-to-back writes run at one per cycle.
- Read: address phase at T0; S_HREADYOUT=0 during T1..T1+WAIT_STATES; data valid with S_HREADYOUT=1 at T2+WAIT_STATES. Latency is 2+WAIT_STATES cycles from accept.
- While S_HREADYOUT=0, a presented address phase is not accepted; the master holds it.
- Error response: exactly 2 cycles, with HRESP=ERROR in both.
- All outputs are registered or decoded from the registered state only; there is no combinational path from bus inputs to S_HREADYOUT.

## Configuration
- AHB_SRAM_ERR_EN defined: these transfers get the two-cycle ERROR response, with no RAM access:
  - misaligned halfword (addr[0]=1);
  - misaligned word (addr[1:0]!=0);
  - HSIZE>2;
  - S_HADDR >= 4*2^ADDR_WIDTH.
- AHB_SRAM_ERR_EN undefined:
  - misaligned low address bits are ignored in favour of the size-aligned lanes;
  - HSIZE>2 is treated as a word;
  - out-of-range addresses wrap modulo the depth;
  - S_HRESP is constant OKAY; ERR1/ERR2 are not generated.

## Structure
- Shared defines file: HTRANS, HSIZE and HRESP codes, `ZeroWord.
- Sub-module ahb_sram_ram: synchronous single-port RAM with a 4-bit byte write enable and 1-cycle read latency. This block holds the FSM, wait counter, lane decode and holding register.

## Test plan
- Word write 0xDEADBEEF @0x10, then word read @0x10, WAIT_STATES=0 -> write with zero wait; read S_HREADYOUT low 1 cycle, then HRDATA=0xDEADBEEF.
- Byte write 0xAA to 0x13 (HWDATA=0xAA000000) over word 0x11223344 -> read returns 0xAA223344; only be=1000 asserted.
- WAIT_STATES=3: read -> S_HREADYOUT low exactly 4 cycles, data on the 5th cycle.
- Back-to-back: write @0x20, then read @0x20 on the next address phase -> read returns the new data.
- With AHB_SRAM_ERR_EN, word read @0x02 -> HRESP=01 for 2 cycles, HREADYOUT 0 then 1, RAM untouched. Without the macro -> reads word @0x00, OKAY.
- rst asserted during RD_WAIT -> next cycle HREADYOUT=1, HRESP=00, HRDATA=0; a fresh read completes normally.
